rv_machine_timer: RTL and testbench
===================================

// Module: rv_machine_timer
// PURPOSE
//  Memory-mapped RISC-V machine timer (mtime/mtimecmp) producing the timer_int level
//  consumed by the CSR file (drives mip.MTIP, bit 7). Sits on the core's peripheral bus.
//  Keeps a free-running 64-bit mtime, advanced by a prescaler. Raises timer_int while mtime >= mtimecmp.
// PARAMETERS
//  PRESCALE   16   clk cycles per mtime increment; legal range 1..65535 (1 = every cycle)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous, active-low reset
//  bus_valid    in   1   request strobe
//  bus_we       in   1   1 = write, 0 = read
//  bus_addr     in   5   byte offset; bits [1:0] ignored
//  bus_wdata    in   32  write data (full-word writes only)
//  bus_ack      out  1   one-cycle response pulse
//  bus_rdata    out  32  read data, valid while bus_ack=1, else 0
//  timer_int    out  1   machine timer interrupt level, to CSR file timer_int
// BEHAVIOUR
//  Register map (word offsets):
//   0x00 MTIME_LO  0x04 MTIME_HI  0x08 MTIMECMP_LO  0x0C MTIMECMP_HI  0x10 CTRL (bit0 EN, others RAZ/WI)
//   Unmapped offsets: read 0, write ignored, still acked.
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=1, prescaler=0, hi_shadow=0,
//   bus_ack=0, bus_rdata=0, timer_int=0.
//  Prescaler: while EN=1, presc counts 0..PRESCALE-1.
//   When presc==PRESCALE-1: presc wraps to 0 and mtime increments by 1.
//   While EN=0, presc and mtime hold.
//  mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
//  Handshake: a request is accepted in any cycle with bus_valid=1 && bus_ack=0.
//   bus_ack=1 exactly the next cycle. Continuously held valid is therefore acked every other cycle.
//   Master must hold inputs stable only in the accept cycle.
//  Reads: bus_rdata is registered from the accept-cycle register value.
//   Reading MTIME_LO also latches mtime[63:32] into hi_shadow in the same edge.
//   Reading MTIME_HI returns hi_shadow, not the live mtime, giving a coherent 64-bit read (LO first).
//  Writes take effect at the accept edge.
//   Writing MTIME_LO/HI replaces that half and resets presc to 0.
//   If a write to mtime coincides with a prescaler increment, the write wins and the increment is lost.
//   Writing MTIMECMP_* replaces that half only; no side effect on mtime.
//   Writing CTRL with EN=0 freezes the counter; the prescaler count is retained.
//  timer_int is registered: timer_int <= (mtime >= mtimecmp), an unsigned 64-bit compare of current register values.
//   Latency is 1 cycle after the crossing or after a mtimecmp write.
//   It is a level: it stays high until software raises mtimecmp or lowers mtime. There is no clear-on-read.
//   It is independent of EN.
//  Reset mid-transaction: any pending ack is dropped and all state returns to reset values.
// TESTING
//  1 Reset, PRESCALE=4, no bus traffic, 40 cycles -> mtime=10, timer_int=0, bus_ack never high.
//  2 Write CMP_HI=0, CMP_LO=5, PRESCALE=1 -> timer_int rises 1 cycle after mtime reaches 5; stays high.
//    Then write CMP_LO=0xFFFF_FFFF -> timer_int falls 1 cycle later.
//  3 Write MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, PRESCALE=1, wait 3 cycles, read LO then HI.
//    -> HI read returns the shadow latched at the LO read (1); coherent with LO.
//  4 Write MTIME_LO=0x100 on the exact cycle presc wraps.
//    -> next-cycle read of MTIME_LO returns 0x100, not 0x101; presc=0.
//  5 Write CTRL=0, wait 50 cycles -> mtime unchanged.
//    Write CTRL=1 -> counting resumes from the retained presc value.
//  6 Hold bus_valid=1 read 0x14 for 6 cycles -> 3 ack pulses, each rdata=0.
//    Assert reset_n=0 with ack pending -> bus_ack=0 and timer_int=0 immediately.

Source files
------------

// File: rtl/rv_machine_timer_if.sv
// Peripheral-bus bundle between the core and the machine timer.
// The master drives requests; the slave returns a one-cycle ack with registered read data.
interface rv_machine_timer_if;
    logic        bus_valid;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/rv_machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a registered
// timer_int level (mtime >= mtimecmp) for mip.MTIP, on a simple valid/ack bus.
module rv_machine_timer #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    rv_machine_timer_if.slave   bus,
    output logic                timer_int
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_CTRL     = 3'd4;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        en_q, en_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        int_q, int_d;

    logic        accept;
    logic        rd_acc;
    logic        wr_acc;
    logic        tick;
    logic [2:0]  word;
    logic        unused_addr_bits;

    assign word             = bus.bus_addr[4:2];
    assign unused_addr_bits = ^bus.bus_addr[1:0];
    assign accept           = bus.bus_valid && !ack_q;
    assign rd_acc           = accept && !bus.bus_we;
    assign wr_acc           = accept && bus.bus_we;
    assign tick             = en_q && (presc_q == PRESC_MAX);

    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d     = en_q ? (tick ? 16'd0 : presc_q + 16'd1) : presc_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        hi_shadow_d = hi_shadow_q;
        rdata_d     = 32'd0;
        ack_d       = accept;
        int_d       = (mtime_q >= mtimecmp_q);

        // A bus write to mtime overrides a coincident prescaler increment.
        if (wr_acc) begin
            case (word)
                W_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], bus.bus_wdata};
                    presc_d = 16'd0;
                end
                W_MTIME_HI: begin
                    mtime_d = {bus.bus_wdata, mtime_q[31:0]};
                    presc_d = 16'd0;
                end
                W_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata};
                W_CMP_HI: mtimecmp_d = {bus.bus_wdata, mtimecmp_q[31:0]};
                W_CTRL:   en_d       = bus.bus_wdata[0];
                default:  ;
            endcase
        end

        // The LO read snapshots the upper half so a following HI read is coherent.
        if (rd_acc) begin
            case (word)
                W_MTIME_LO: begin
                    rdata_d     = mtime_q[31:0];
                    hi_shadow_d = mtime_q[63:32];
                end
                W_MTIME_HI: rdata_d = hi_shadow_q;
                W_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                W_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                W_CTRL:     rdata_d = {31'd0, en_q};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q     <= 16'd0;
            en_q        <= 1'b1;
            hi_shadow_q <= 32'd0;
            ack_q       <= 1'b0;
            rdata_q     <= 32'd0;
            int_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_q     <= presc_d;
            en_q        <= en_d;
            hi_shadow_q <= hi_shadow_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            int_q       <= int_d;
        end
    end

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;
    assign timer_int     = int_q;

endmodule

// File: tb/tb_rv_machine_timer.sv
// Randomized and directed bench for rv_machine_timer against a count-based reference model.
module tb_rv_machine_timer;

    localparam int P = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic timer_int;

    rv_machine_timer_if bus();

    rv_machine_timer #(.PRESCALE(P)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .timer_int (timer_int)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mtime is a base value plus whole prescale periods of enabled cycles.
    logic [63:0]     m_base;
    logic [63:0]     m_cmp;
    longint unsigned m_ecnt;
    bit              m_en;
    logic [31:0]     m_shadow;
    bit              m_ack;
    logic [31:0]     m_rdata;
    bit              m_int;

    function automatic logic [63:0] m_mtime();
        return m_base + m_ecnt / 64'(P);
    endfunction

    task automatic model_reset();
        m_base   = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_ecnt   = 0;
        m_en     = 1'b1;
        m_shadow = 32'd0;
        m_ack    = 1'b0;
        m_rdata  = 32'd0;
        m_int    = 1'b0;
    endtask

    task automatic step();
        logic [63:0] mt;
        logic [2:0]  w;
        logic [31:0] nx_rdata;
        bit          acc;
        bit          nx_int;
        mt       = m_mtime();
        w        = bus.bus_addr[4:2];
        acc      = bus.bus_valid && !m_ack;
        nx_int   = (mt >= m_cmp);
        nx_rdata = 32'd0;
        if (acc && !bus.bus_we) begin
            case (w)
                3'd0: nx_rdata = mt[31:0];
                3'd1: nx_rdata = m_shadow;
                3'd2: nx_rdata = m_cmp[31:0];
                3'd3: nx_rdata = m_cmp[63:32];
                3'd4: nx_rdata = {31'd0, m_en};
                default: nx_rdata = 32'd0;
            endcase
            if (w == 3'd0) m_shadow = mt[63:32];
        end
        if (m_en) m_ecnt++;
        if (acc && bus.bus_we) begin
            case (w)
                3'd0: begin m_base = {mt[63:32], bus.bus_wdata}; m_ecnt = 0; end
                3'd1: begin m_base = {bus.bus_wdata, mt[31:0]}; m_ecnt = 0; end
                3'd2: m_cmp = {m_cmp[63:32], bus.bus_wdata};
                3'd3: m_cmp = {bus.bus_wdata, m_cmp[31:0]};
                3'd4: m_en = bus.bus_wdata[0];
                default: ;
            endcase
        end
        m_ack   = acc;
        m_rdata = nx_rdata;
        m_int   = nx_int;
        @(posedge clk);
        #1;
        check_eq("ack", 64'(bus.bus_ack), 64'(m_ack));
        check_eq("rdata", 64'(bus.bus_rdata), 64'(m_rdata));
        check_eq("timer_int", 64'(timer_int), 64'(m_int));
    endtask

    task automatic bus_op(input bit we, input logic [4:0] addr, input logic [31:0] data,
                          output logic [31:0] rd);
        bus.bus_valid = 1'b0;
        while (m_ack) step();
        bus.bus_valid = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = data;
        step();
        rd = bus.bus_rdata;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_wdata = $urandom;
    endtask

    task automatic apply_reset();
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        reset_n       = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ack", 64'(bus.bus_ack), 64'd0);
        check_eq("rst_rdata", 64'(bus.bus_rdata), 64'd0);
        check_eq("rst_int", 64'(timer_int), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, b;
        logic [63:0] mt;
        int          acks;
        int          k;
        bus.bus_valid = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 5'd0;
        bus.bus_wdata = 32'd0;
        @(posedge clk);
        #1;
        apply_reset();

        // Free-running count from reset
        repeat (40) step();
        bus_op(1'b0, 5'h00, 32'd0, rd);
        check_eq("t1_mtime", 64'(rd), 64'd10);

        // Compare crossing and release
        mt = m_mtime();
        bus_op(1'b1, 5'h0C, 32'd0, rd);
        bus_op(1'b1, 5'h08, mt[31:0] + 32'd5, rd);
        k = 0;
        while (!timer_int && k < 100) begin step(); k++; end
        check_eq("t2_rise", 64'(timer_int), 64'd1);
        repeat (10) step();
        check_eq("t2_hold", 64'(timer_int), 64'd1);
        bus_op(1'b1, 5'h08, 32'hFFFF_FFFF, rd);
        step();
        check_eq("t2_fall", 64'(timer_int), 64'd0);

        // Coherent 64-bit read across a carry
        bus_op(1'b1, 5'h00, 32'hFFFF_FFFF, rd);
        bus_op(1'b1, 5'h04, 32'd0, rd);
        repeat (3 * P) step();
        bus_op(1'b0, 5'h00, 32'd0, a);
        repeat (2 * P) step();
        bus_op(1'b0, 5'h04, 32'd0, b);
        check_eq("t3_hi_shadow", 64'(b), 64'd1);

        // Write coinciding with a prescaler wrap
        k = 0;
        while ((m_ack || (m_ecnt % 64'(P)) != 64'(P - 1)) && k < 4 * P) begin step(); k++; end
        check_eq("t4_align", m_ecnt % 64'(P), 64'(P - 1));
        bus_op(1'b1, 5'h00, 32'h100, rd);
        bus_op(1'b0, 5'h00, 32'd0, rd);
        check_eq("t4_write_wins", 64'(rd), 64'h100);

        // Freeze and resume
        bus_op(1'b1, 5'h10, 32'd0, rd);
        bus_op(1'b0, 5'h00, 32'd0, a);
        repeat (50) step();
        bus_op(1'b0, 5'h00, 32'd0, b);
        check_eq("t5_frozen", 64'(b), 64'(a));
        bus_op(1'b1, 5'h10, 32'd1, rd);
        repeat (3 * P) step();
        bus_op(1'b0, 5'h10, 32'd0, rd);
        check_eq("t5_ctrl_en", 64'(rd), 64'd1);

        // Back-to-back reads of an unmapped word, then reset with ack pending
        bus_op(1'b1, 5'h0C, 32'd0, rd);
        bus_op(1'b1, 5'h08, 32'd0, rd);
        step();
        step();
        bus.bus_valid = 1'b1;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 5'h14;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.bus_ack) acks++;
        end
        check_eq("t6_acks", 64'(acks), 64'd3);
        step();
        check_eq("t6_pending", 64'(bus.bus_ack), 64'd1);
        check_eq("t6_int_before", 64'(timer_int), 64'd1);
        apply_reset();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel;
            logic [4:0]  ad;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            ad  = {3'($urandom_range(0, 7)), 2'($urandom)};
            mt  = m_mtime();
            d   = $urandom;
            if (ad[4:2] == 3'd2)      d = mt[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
            else if (ad[4:2] == 3'd3) d = mt[63:32];
            else if (ad[4:2] == 3'd4) d = {31'($urandom), ($urandom_range(0, 3) != 0)};
            else if (ad[4:2] <= 3'd1 && $urandom_range(0, 3) != 0) d = mt[31:0] + 32'($urandom_range(0, 8));
            if (sel < 4) step();
            else bus_op(sel < 6, ad, d, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
